sfu_accum_wb: RTL and testbench
===============================

// Module: sfu_accum_wb
// PURPOSE
//  Special-function stage directly downstream of the systolic array's output FIFO and upstream of the output SRAM.
//  Pops partial-sum rows, accumulates them over all kernel positions (kij) into a 16-row accumulator, applies ReLU,
//  writes the 16 result rows to output SRAM and raises sfu_done; results are also readable via a debug port.
// PARAMETERS
//  COL       8   array columns (psum lanes per row)
//  PSUM_BW   16  signed psum/accumulator width per lane
//  NUM_ROWS  16  output pixels = accumulator rows = output SRAM depth
//  NUM_KIJ   9   kernel positions accumulated per pass
//  ADDR_W    4   output SRAM address width (log2 NUM_ROWS)
// PORTS
//  clk         in   1              single clock, rising edge
//  reset       in   1              asynchronous, active-low reset (0 = reset)
//  start       in   1              begin new pass; sampled only in IDLE/DONE
//  ofifo_valid in   1              OFIFO non-empty; ofifo_data valid same cycle (first-word fall-through)
//  ofifo_data  in   COL*PSUM_BW    one psum row, lane c at [c*PSUM_BW +: PSUM_BW]
//  ofifo_rd    out  1              pop strobe
//  op_cen      out  1              output SRAM chip enable, active-low
//  op_wen      out  1              output SRAM write enable, active-low
//  op_addr     out  ADDR_W         output SRAM address
//  op_d        out  COL*PSUM_BW    output SRAM write data
//  busy        out  1              high in ACCUM or WB
//  sfu_done    out  1              level; high in DONE
//  rd_idx      in   ADDR_W         debug read row select
//  rd_data     out  COL*PSUM_BW    combinational accumulator row rd_idx
// BEHAVIOUR
//  - Reset (async assert, sync deassert): state=IDLE, accumulator all 0, counters 0, ofifo_rd=0, op_cen=1, op_wen=1,
//    op_addr=0, op_d=0, busy=0, sfu_done=0. Reset mid-pass aborts at once; no further pops or SRAM writes.
//  - FSM IDLE -> ACCUM -> WB -> DONE -> (start) ACCUM.
//  - IDLE/DONE: start=1 on edge -> clear all rows, row_cnt=kij_cnt=0, sfu_done falls, enter ACCUM. start ignored elsewhere.
//  - ACCUM: ofifo_rd = ofifo_valid (combinational; 0 in every other state). On each popping edge, per lane c:
//    acc[row_cnt][c] <= acc[row_cnt][c] + ofifo_data lane c, two's-complement, truncated to PSUM_BW (wraps, no saturation).
//    row_cnt 0..NUM_ROWS-1 wraps to 0 and increments kij_cnt. Pop at row_cnt=NUM_ROWS-1, kij_cnt=NUM_KIJ-1 -> WB, wb_cnt=0.
//    Cycles with ofifo_valid=0 stall; no counter changes.
//  - WB: exactly NUM_ROWS consecutive cycles; in WB cycle k: op_cen=0, op_wen=0, op_addr=k, op_d=ReLU(acc[k]) per lane
//    (lane MSB set -> 0, else unchanged); acc[k] overwritten with ReLU value on that edge. After k=NUM_ROWS-1 -> DONE.
//  - DONE: op_cen=op_wen=1, sfu_done=1, accumulator holds ReLU results until next start.
//  - Latency: with ofifo_valid held high, 144 pop cycles + 16 WB cycles; sfu_done high 160 cycles after start edge.
//  - rd_data reflects current accumulator contents in every state (raw sums in ACCUM, ReLU results after WB).
// TESTING
//  T1 reset low mid-cycle in ACCUM -> all outputs at reset values immediately, ofifo_rd=0, no SRAM write follows.
//  T2 every lane=16'h0001, valid held high -> 144 pops, 16 writes addr 0..15 of {8{16'h0009}}, sfu_done at cycle 160.
//  T3 lanes 0-3=16'hFFFF, 4-7=16'h0002 all pops -> sums -9/+18; op_d each row = {4{16'h0012},4{16'h0000}} (lanes 7..0).
//  T4 every lane=16'h7000 -> sum wraps to 16'hF000 (negative) -> all written data 0; rd_data row 0 reads 0 in DONE.
//  T5 ofifo_valid toggled every cycle -> exactly 144 pops, results equal T2, no ofifo_rd while valid=0.
//  T6 start pulsed during ACCUM and WB -> ignored; second start in DONE -> accumulator cleared, fresh T2 results repeat.

Source files
------------

// File: rtl/sfu_accum_wb_if.sv
// Bus bundle between the SFU stage, the upstream output FIFO and the
// downstream output SRAM.
//
// Handshake: the FIFO is first-word fall-through. ofifo_data is valid
// whenever ofifo_valid is high. A word is consumed on a rising clock edge
// where ofifo_rd is high, and ofifo_rd is only ever high while ofifo_valid
// is high. The SRAM port is active-low: a write happens on every rising
// edge where op_cen and op_wen are both low.
interface sfu_accum_wb_if #(
   parameter int COL     = 8,
   parameter int PSUM_BW = 16,
   parameter int ADDR_W  = 4
) ();
   logic                   ofifo_valid;
   logic [COL*PSUM_BW-1:0] ofifo_data;
   logic                   ofifo_rd;
   logic                   op_cen;
   logic                   op_wen;
   logic [ADDR_W-1:0]      op_addr;
   logic [COL*PSUM_BW-1:0] op_d;

   // SFU side: consumes FIFO words, drives the SRAM port
   modport master (
      input  ofifo_valid, ofifo_data,
      output ofifo_rd, op_cen, op_wen, op_addr, op_d
   );

   // Environment side: FIFO source and SRAM sink
   modport slave (
      output ofifo_valid, ofifo_data,
      input  ofifo_rd, op_cen, op_wen, op_addr, op_d
   );
endinterface

// File: rtl/sfu_accum_wb.sv
// Special-function stage: accumulates partial-sum rows over all kernel
// positions into a row accumulator, applies ReLU while writing the rows to
// the output SRAM, then holds the results (readable on the debug port)
// until the next start.
module sfu_accum_wb #(
   parameter int COL      = 8,
   parameter int PSUM_BW  = 16,
   parameter int NUM_ROWS = 16,
   parameter int NUM_KIJ  = 9,
   parameter int ADDR_W   = 4
) (
   input  logic                   clk,
   input  logic                   reset,      // asynchronous, active-low
   input  logic                   start,
   input  logic [ADDR_W-1:0]      rd_idx,
   sfu_accum_wb_if.master         bus,
   output logic                   busy,
   output logic                   sfu_done,
   output logic [COL*PSUM_BW-1:0] rd_data,
   output logic [1:0]             dbg_state
);

   localparam int ROW_W = COL * PSUM_BW;
   localparam int KIJ_W = (NUM_KIJ > 1) ? $clog2(NUM_KIJ) : 1;
   localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(NUM_ROWS - 1);
   localparam logic [KIJ_W-1:0]  LAST_KIJ = KIJ_W'(NUM_KIJ - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_WB    = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   row_cnt_q, row_cnt_d;
   logic [KIJ_W-1:0]    kij_cnt_q, kij_cnt_d;
   logic [ADDR_W-1:0]   wb_cnt_q, wb_cnt_d;
   logic [ROW_W-1:0]    acc_q [NUM_ROWS];

   logic                clear_acc;
   logic                pop;
   logic                wb_wr;
   logic [ROW_W-1:0]    wb_row;

   // Lane-wise two's-complement add, each lane wraps at PSUM_BW bits
   function automatic logic [ROW_W-1:0] add_row(input logic [ROW_W-1:0] a,
                                                input logic [ROW_W-1:0] b);
      logic [ROW_W-1:0] s;
      s = '0;
      for (int c = 0; c < COL; c++) begin
         s[c*PSUM_BW +: PSUM_BW] = a[c*PSUM_BW +: PSUM_BW] + b[c*PSUM_BW +: PSUM_BW];
      end
      return s;
   endfunction

   // Lane-wise ReLU: a lane with its sign bit set becomes zero
   function automatic logic [ROW_W-1:0] relu_row(input logic [ROW_W-1:0] a);
      logic [ROW_W-1:0] r;
      r = a;
      for (int c = 0; c < COL; c++) begin
         if (a[c*PSUM_BW + PSUM_BW - 1]) begin
            r[c*PSUM_BW +: PSUM_BW] = '0;
         end
      end
      return r;
   endfunction

   // State and counter registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         row_cnt_q <= '0;
         kij_cnt_q <= '0;
         wb_cnt_q  <= '0;
      end else begin
         state_q   <= state_d;
         row_cnt_q <= row_cnt_d;
         kij_cnt_q <= kij_cnt_d;
         wb_cnt_q  <= wb_cnt_d;
      end
   end

   // Next-state, counter advance and per-cycle action strobes
   always_comb begin
      state_d   = state_q;
      row_cnt_d = row_cnt_q;
      kij_cnt_d = kij_cnt_q;
      wb_cnt_d  = wb_cnt_q;
      clear_acc = 1'b0;
      pop       = 1'b0;
      wb_wr     = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d   = S_ACCUM;
               clear_acc = 1'b1;
               row_cnt_d = '0;
               kij_cnt_d = '0;
               wb_cnt_d  = '0;
            end
         end
         S_ACCUM: begin
            // No word available means a stall: nothing advances
            if (bus.ofifo_valid) begin
               pop = 1'b1;
               if (row_cnt_q == LAST_ROW) begin
                  row_cnt_d = '0;
                  if (kij_cnt_q == LAST_KIJ) begin
                     kij_cnt_d = '0;
                     wb_cnt_d  = '0;
                     state_d   = S_WB;
                  end else begin
                     kij_cnt_d = kij_cnt_q + KIJ_W'(1);
                  end
               end else begin
                  row_cnt_d = row_cnt_q + ADDR_W'(1);
               end
            end
         end
         S_WB: begin
            wb_wr = 1'b1;
            if (wb_cnt_q == LAST_ROW) begin
               wb_cnt_d = '0;
               state_d  = S_DONE;
            end else begin
               wb_cnt_d = wb_cnt_q + ADDR_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Accumulator rows: cleared on start, summed on pops, rectified on write-back
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int r = 0; r < NUM_ROWS; r++) begin
            acc_q[r] <= '0;
         end
      end else if (clear_acc) begin
         for (int r = 0; r < NUM_ROWS; r++) begin
            acc_q[r] <= '0;
         end
      end else if (pop) begin
         acc_q[row_cnt_q] <= add_row(acc_q[row_cnt_q], bus.ofifo_data);
      end else if (wb_wr) begin
         acc_q[wb_cnt_q] <= wb_row;
      end
   end

   // Write-back row is the rectified accumulator row being written this cycle
   assign wb_row       = relu_row(acc_q[wb_cnt_q]);

   assign bus.ofifo_rd = pop;
   assign bus.op_cen   = ~wb_wr;
   assign bus.op_wen   = ~wb_wr;
   assign bus.op_addr  = wb_wr ? wb_cnt_q : '0;
   assign bus.op_d     = wb_wr ? wb_row : '0;

   assign busy         = (state_q == S_ACCUM) || (state_q == S_WB);
   assign sfu_done     = (state_q == S_DONE);
   assign rd_data      = acc_q[rd_idx];
   assign dbg_state    = state_q;

endmodule

// File: tb/tb_sfu_accum_wb.sv
// Directed bench for sfu_accum_wb: full passes with constant psum rows,
// valid toggling, ignored start pulses, and reset in the middle of a pass.
module tb_sfu_accum_wb;

   localparam int COL = 8, PSUM_BW = 16, ADDR_W = 4, ROW_W = COL * PSUM_BW;

   logic              clk;
   logic              reset;
   logic              start;
   logic [ADDR_W-1:0] rd_idx;
   logic              busy;
   logic              sfu_done;
   logic [ROW_W-1:0]  rd_data;
   logic [1:0]        dbg_state;

   sfu_accum_wb_if #(.COL(COL), .PSUM_BW(PSUM_BW), .ADDR_W(ADDR_W)) bus ();

   sfu_accum_wb dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .rd_idx    (rd_idx),
      .bus       (bus),
      .busy      (busy),
      .sfu_done  (sfu_done),
      .rd_data   (rd_data),
      .dbg_state (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   int               n_checks = 0;
   int               n_pass   = 0;
   int               pop_cnt  = 0;
   int               bad_rd   = 0;
   logic [ADDR_W-1:0] wr_addr_q[$];
   logic [ROW_W-1:0]  wr_data_q[$];
   logic [ROW_W-1:0]  exp_q[$];

   task automatic chk(input string tag, input logic [ROW_W-1:0] got,
                      input logic [ROW_W-1:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // Observe the bus mid-cycle; whatever is seen here acts on the next rising edge
   always @(negedge clk) begin
      if (reset) begin
         if (bus.ofifo_rd) pop_cnt++;
         if (bus.ofifo_rd && !bus.ofifo_valid) bad_rd++;
         if (!bus.op_cen && !bus.op_wen) begin
            wr_addr_q.push_back(bus.op_addr);
            wr_data_q.push_back(bus.op_d);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_sb();
      pop_cnt = 0;
      bad_rd  = 0;
      wr_addr_q.delete();
      wr_data_q.delete();
   endtask

   task automatic chk_reset_outputs(input string tag);
      rd_idx = '0;
      #1;
      chk({tag, "_ofifo_rd"}, ROW_W'(bus.ofifo_rd), '0);
      chk({tag, "_op_cen"},   ROW_W'(bus.op_cen),   ROW_W'(1));
      chk({tag, "_op_wen"},   ROW_W'(bus.op_wen),   ROW_W'(1));
      chk({tag, "_op_addr"},  ROW_W'(bus.op_addr),  '0);
      chk({tag, "_op_d"},     bus.op_d,             '0);
      chk({tag, "_busy"},     ROW_W'(busy),         '0);
      chk({tag, "_done"},     ROW_W'(sfu_done),     '0);
      chk({tag, "_state"},    ROW_W'(dbg_state),    '0);
      chk({tag, "_rd_row0"},  rd_data,              '0);
   endtask

   // One full pass from a start edge; psum row is constant for every pop.
   // raw_exp is row 0 after edge 20 (two kij passes over row 0) when not toggling.
   task automatic run_pass(input string tag, input logic [ROW_W-1:0] row,
                           input bit toggle, input bit pulse,
                           input logic [ROW_W-1:0] raw_exp,
                           input logic [ROW_W-1:0] exp_row, input int exp_cycles);
      int cycles;
      clear_sb();
      exp_q.delete();
      for (int k = 0; k < 16; k++) exp_q.push_back(exp_row);
      bus.ofifo_data  = row;
      bus.ofifo_valid = 1'b1;
      start = 1'b1;
      tick();
      start  = 1'b0;
      cycles = 0;
      while (!sfu_done && cycles < 1000) begin
         bus.ofifo_valid = toggle ? ((cycles % 2) == 0) : 1'b1;
         start = pulse && (cycles == 50 || cycles == 150);
         tick();
         cycles++;
         if (cycles == 1) begin
            chk({tag, "_busy_after_start"}, ROW_W'(busy),     ROW_W'(1));
            chk({tag, "_done_low"},         ROW_W'(sfu_done), '0);
         end
         if (!toggle && cycles == 20) begin
            rd_idx = '0;
            #1;
            chk({tag, "_raw_row0"}, rd_data, raw_exp);
         end
      end
      start = 1'b0;
      bus.ofifo_valid = 1'b1;
      tick();
      chk({tag, "_cycles"},   ROW_W'(cycles),          ROW_W'(exp_cycles));
      chk({tag, "_pops"},     ROW_W'(pop_cnt),         ROW_W'(144));
      chk({tag, "_bad_rd"},   ROW_W'(bad_rd),          '0);
      chk({tag, "_n_writes"}, ROW_W'(wr_data_q.size()), ROW_W'(16));
      chk({tag, "_busy_end"}, ROW_W'(busy),            '0);
      chk({tag, "_done_end"}, ROW_W'(sfu_done),        ROW_W'(1));
      for (int k = 0; k < 16 && k < wr_data_q.size(); k++) begin
         chk($sformatf("%s_wr_addr%0d", tag, k), ROW_W'(wr_addr_q[k]), ROW_W'(k));
         chk($sformatf("%s_wr_data%0d", tag, k), wr_data_q[k], exp_q[k]);
      end
      for (int r = 0; r < 16; r += 5) begin
         rd_idx = ADDR_W'(r);
         #1;
         chk($sformatf("%s_rd_row%0d", tag, r), rd_data, exp_row);
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [ROW_W-1:0] t2_row, t2_raw, t2_exp;
      logic [ROW_W-1:0] t3_row, t3_raw, t3_exp;
      logic [ROW_W-1:0] t4_row, t4_raw;
      t2_row = {8{16'h0001}};
      t2_raw = {8{16'h0002}};
      t2_exp = {8{16'h0009}};
      t3_row = {{4{16'h0002}}, {4{16'hFFFF}}};
      t3_raw = {{4{16'h0004}}, {4{16'hFFFE}}};
      t3_exp = {{4{16'h0012}}, {4{16'h0000}}};
      t4_row = {8{16'h7000}};
      t4_raw = {8{16'hE000}};

      reset = 1'b0;
      start = 1'b0;
      rd_idx = '0;
      bus.ofifo_valid = 1'b0;
      bus.ofifo_data  = '0;
      #2;
      chk_reset_outputs("por");
      #20;
      reset = 1'b1;
      tick();

      // Plain pass, valid held high
      run_pass("t2", t2_row, 1'b0, 1'b0, t2_raw, t2_exp, 160);
      // Mixed-sign lanes, started from DONE
      run_pass("t3", t3_row, 1'b0, 1'b0, t3_raw, t3_exp, 160);
      // Lane sums wrap negative, rectified to zero
      run_pass("t4", t4_row, 1'b0, 1'b0, t4_raw, '0, 160);
      // Valid toggling: pops on every other edge, 144th pop at edge 287
      run_pass("t5", t2_row, 1'b1, 1'b0, '0, t2_exp, 303);
      // Start pulses during ACCUM and WB are ignored
      run_pass("t6a", t2_row, 1'b0, 1'b1, t2_raw, t2_exp, 160);
      // Second start from DONE clears and repeats
      run_pass("t6b", t2_row, 1'b0, 1'b0, t2_raw, t2_exp, 160);

      // Reset mid-cycle during ACCUM
      clear_sb();
      bus.ofifo_data  = t2_row;
      bus.ofifo_valid = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 30; i++) tick();
      chk("t1_busy_before", ROW_W'(busy), ROW_W'(1));
      #1;
      reset = 1'b0;
      chk_reset_outputs("t1");
      clear_sb();
      for (int i = 0; i < 3; i++) tick();
      #2;
      reset = 1'b1;
      for (int i = 0; i < 20; i++) tick();
      chk("t1_pops_after", ROW_W'(pop_cnt), '0);
      chk("t1_writes_after", ROW_W'(wr_data_q.size()), '0);
      chk("t1_state_after", ROW_W'(dbg_state), '0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
